// File: rtl/hg_query_arbiter_pkg.sv
// Shared widths, requester ids and default credit budget for the homography query arbiter.
package hg_query_arbiter_pkg;
    localparam int COORD_W             = 10;
    localparam int R_W                 = 5;
    localparam int G_W                 = 6;
    localparam int B_W                 = 5;
    localparam int OUT_W               = 3;
    localparam int STAT_W              = 16;
    localparam int MAX_OUTSTANDING_DEF = 5;
    localparam int TAG_AW_DEF          = 3;

    localparam logic REQ_DVI = 1'b0;
    localparam logic REQ_CCD = 1'b1;
endpackage

// File: rtl/hg_query_arbiter_tag_fifo.sv
// Circular 1-bit tag FIFO; its occupancy count doubles as the in-flight credit counter.
module hg_tag_fifo
    import hg_query_arbiter_pkg::*;
#(
    parameter int DEPTH = MAX_OUTSTANDING_DEF,
    parameter int AW    = TAG_AW_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             din_i,
    output logic             dout_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [OUT_W-1:0] count_o
);
    localparam logic [OUT_W-1:0] DEPTH_C = OUT_W'(DEPTH);
    localparam logic [AW-1:0]    LAST_C  = AW'(DEPTH - 1);

    logic [2**AW-1:0] mem_q;
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [OUT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == DEPTH_C);
    assign count_o = count_q;
    assign dout_o  = mem_q[rptr_q];

    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign push_ok = push_i & (~full_o | pop_i);
    assign pop_ok  = pop_i & ~empty_o;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push_ok) begin
            wptr_d = (wptr_q == LAST_C) ? '0 : wptr_q + AW'(1);
        end
        if (pop_ok) begin
            rptr_d = (rptr_q == LAST_C) ? '0 : rptr_q + AW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + OUT_W'(1);
            2'b01:   count_d = count_q - OUT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wptr_q] <= din_i;
        end
    end
endmodule

// File: rtl/hg_query_arbiter.sv
// Round-robin, credit-limited sharing of the homography lookup between the DVI and CCD paths.
// Optional grant statistics outputs are enabled with `define HG_ARB_STATS_EN.
module hg_query_arbiter
    import hg_query_arbiter_pkg::*;
#(
    parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEF,
    parameter int TAG_AW          = TAG_AW_DEF
) (
    input  logic               clk_25,
    input  logic               rst_n,
    input  logic               req0_valid,
    input  logic [COORD_W-1:0] req0_x,
    input  logic [COORD_W-1:0] req0_y,
    output logic               req0_grant,
    input  logic               req1_valid,
    input  logic [COORD_W-1:0] req1_x,
    input  logic [COORD_W-1:0] req1_y,
    output logic               req1_grant,
    output logic               start,
    output logic [COORD_W-1:0] query_x,
    output logic [COORD_W-1:0] query_y,
    input  logic               ready,
    input  logic [R_W-1:0]     r,
    input  logic [G_W-1:0]     g,
    input  logic [B_W-1:0]     b,
    output logic               rsp0_valid,
    output logic               rsp1_valid,
    output logic [R_W-1:0]     rsp_r,
    output logic [G_W-1:0]     rsp_g,
    output logic [B_W-1:0]     rsp_b,
    output logic [OUT_W-1:0]   outstanding,
    output logic               err
`ifdef HG_ARB_STATS_EN
    ,
    output logic [STAT_W-1:0]  gnt0_cnt,
    output logic [STAT_W-1:0]  gnt1_cnt
`endif
);
    logic               last_grant_q, last_grant_d;
    logic               start_q, start_d;
    logic [COORD_W-1:0] query_x_q, query_x_d;
    logic [COORD_W-1:0] query_y_q, query_y_d;
    logic               rsp0_valid_q, rsp0_valid_d;
    logic               rsp1_valid_q, rsp1_valid_d;
    logic [R_W-1:0]     rsp_r_q, rsp_r_d;
    logic [G_W-1:0]     rsp_g_q, rsp_g_d;
    logic [B_W-1:0]     rsp_b_q, rsp_b_d;
    logic               err_q, err_d;

    logic               fifo_empty, fifo_full, fifo_tag;
    logic               can_issue, grant0, grant1, grant_any, pop;

    hg_tag_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .AW    (TAG_AW)
    ) u_tag_fifo (
        .clk     (clk_25),
        .rst_n   (rst_n),
        .push_i  (grant_any),
        .pop_i   (ready),
        .din_i   (grant1),
        .dout_o  (fifo_tag),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .count_o (outstanding)
    );

    // A returning result frees its credit in time for a same-cycle issue.
    assign can_issue = ~fifo_full | ready;
    assign pop       = ready & ~fifo_empty;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (can_issue) begin
            if (req0_valid && req1_valid) begin
                if (last_grant_q == REQ_DVI) grant1 = 1'b1;
                else                         grant0 = 1'b1;
            end else if (req0_valid) begin
                grant0 = 1'b1;
            end else if (req1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    assign grant_any  = grant0 | grant1;
    assign req0_grant = grant0;
    assign req1_grant = grant1;

    always_comb begin
        last_grant_d = last_grant_q;
        start_d      = grant_any;
        query_x_d    = query_x_q;
        query_y_d    = query_y_q;
        rsp0_valid_d = pop & (fifo_tag == REQ_DVI);
        rsp1_valid_d = pop & (fifo_tag == REQ_CCD);
        rsp_r_d      = rsp_r_q;
        rsp_g_d      = rsp_g_q;
        rsp_b_d      = rsp_b_q;
        err_d        = err_q | (ready & fifo_empty);
        if (grant0) begin
            last_grant_d = REQ_DVI;
            query_x_d    = req0_x;
            query_y_d    = req0_y;
        end else if (grant1) begin
            last_grant_d = REQ_CCD;
            query_x_d    = req1_x;
            query_y_d    = req1_y;
        end
        if (pop) begin
            rsp_r_d = r;
            rsp_g_d = g;
            rsp_b_d = b;
        end
    end

    always_ff @(posedge clk_25) begin
        if (!rst_n) begin
            last_grant_q <= REQ_CCD;
            start_q      <= 1'b0;
            query_x_q    <= '0;
            query_y_q    <= '0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp_r_q      <= '0;
            rsp_g_q      <= '0;
            rsp_b_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            start_q      <= start_d;
            query_x_q    <= query_x_d;
            query_y_q    <= query_y_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp_r_q      <= rsp_r_d;
            rsp_g_q      <= rsp_g_d;
            rsp_b_q      <= rsp_b_d;
            err_q        <= err_d;
        end
    end

    assign start      = start_q;
    assign query_x    = query_x_q;
    assign query_y    = query_y_q;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp_r      = rsp_r_q;
    assign rsp_g      = rsp_g_q;
    assign rsp_b      = rsp_b_q;
    assign err        = err_q;

`ifdef HG_ARB_STATS_EN
    logic [STAT_W-1:0] gnt0_cnt_q, gnt0_cnt_d;
    logic [STAT_W-1:0] gnt1_cnt_q, gnt1_cnt_d;

    always_comb begin
        gnt0_cnt_d = gnt0_cnt_q;
        gnt1_cnt_d = gnt1_cnt_q;
        if (grant0 && (gnt0_cnt_q != '1)) gnt0_cnt_d = gnt0_cnt_q + STAT_W'(1);
        if (grant1 && (gnt1_cnt_q != '1)) gnt1_cnt_d = gnt1_cnt_q + STAT_W'(1);
    end

    always_ff @(posedge clk_25) begin
        if (!rst_n) begin
            gnt0_cnt_q <= '0;
            gnt1_cnt_q <= '0;
        end else begin
            gnt0_cnt_q <= gnt0_cnt_d;
            gnt1_cnt_q <= gnt1_cnt_d;
        end
    end

    assign gnt0_cnt = gnt0_cnt_q;
    assign gnt1_cnt = gnt1_cnt_q;
`endif
endmodule

// File: doc/hg_query_arbiter.md
Name: hg_query_arbiter

Overview:
- Shares the single homography lookup unit between two pixel-query requesters: requester 0 is the DVI/colour-transform path, requester 1 is the CCD overlay path.
- Issues at most one query per cycle and limits in-flight queries to a credit budget.
- Tags each query with its requester and routes each in-order homography result back to the requester that issued it.
- Sits between the colour-transform FIFO readers and the homography block, upstream of the sync controller.

Parameters:
- MAX_OUTSTANDING, 5, maximum queries in flight at the homography unit (1..7).
- TAG_AW, 3, address width of the internal tag FIFO; 2**TAG_AW >= MAX_OUTSTANDING.

Ports:
- clk_25  in  1  system clock, 25 MHz.
- rst_n  in  1  reset, synchronous, active-low.
- req0_valid  in  1  requester 0 has a query.
- req0_x  in  10  requester 0 query x.
- req0_y  in  10  requester 0 query y.
- req0_grant  out  1  combinational; query 0 accepted this cycle.
- req1_valid, req1_x, req1_y, req1_grant  same as requester 0.
- start  out  1  registered one-cycle issue pulse to the homography unit.
- query_x  out  10  registered query x.
- query_y  out  10  registered query y.
- ready  in  1  homography result valid, one cycle per result, strictly in issue order.
- r  in  5  result red.
- g  in  6  result green.
- b  in  5  result blue.
- rsp0_valid  out  1  registered; result for requester 0.
- rsp1_valid  out  1  registered; result for requester 1.
- rsp_r  out  5  registered result red (shared by both requesters).
- rsp_g  out  6  registered result green.
- rsp_b  out  5  registered result blue.
- outstanding  out  3  registered in-flight count.
- err  out  1  sticky protocol-error flag.

Behaviour:
- Reset (rst_n low at clk_25 edge): every output register goes to 0, the tag FIFO is emptied, last_grant is set to 1 (requester 0 wins first). Reset mid-operation discards in-flight tags; results returned after reset are treated as orphans (see err).
- can_issue = (outstanding < MAX_OUTSTANDING) OR ready this cycle (the returning credit may be reused in the same cycle).
- Arbitration, round-robin:
  - Only req0_valid set: grant 0.
  - Only req1_valid set: grant 1.
  - Both set: grant the requester not equal to last_grant.
  - No grant when can_issue is 0.
  - At most one reqN_grant is high per cycle.
  - last_grant updates only when a grant is given.
- Issue: on a grant, the next cycle has start=1 and query_x/query_y equal to the granted coordinates; the tag FIFO pushes the granted id. Without a grant, start=0 and query_x/query_y hold their values.
- Return: on ready=1 with the tag FIFO non-empty, pop the tag. The next cycle has rspT_valid=1 and rsp_r/g/b equal to r/g/b. The two rsp valids are never high together. rsp_r/g/b hold their values when no result is delivered.
- ready=1 with the tag FIFO empty: result dropped, err set to 1 and held until reset; outstanding unchanged.
- outstanding:
  - +1 on issue.
  - -1 on a valid return.
  - Unchanged when issue and return occur in the same cycle.
  - Never exceeds MAX_OUTSTANDING and never wraps below 0.
- Tag FIFO: circular, with read and write pointers of TAG_AW bits that wrap at MAX_OUTSTANDING; full and empty are derived from outstanding.
- Latency:
  - Grant to start: 1 cycle.
  - ready to rsp valid: 1 cycle.
  - A back-to-back full budget sustains one query per cycle when results also return one per cycle.

Optional Feature:
- HG_ARB_STATS_EN defined: adds outputs gnt0_cnt[15:0] and gnt1_cnt[15:0]. Each is a saturating count of grants per requester that holds at 16'hFFFF and resets to 0.
- Macro undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - coordinate width 10;
  - RGB565 field widths 5/6/5;
  - requester id constants REQ_DVI=0 and REQ_CCD=1;
  - default MAX_OUTSTANDING.
- One sub-module: hg_tag_fifo, a parameterised depth by 1-bit synchronous FIFO with push/pop/empty/full.

Test Plan:
- Reset, then req0_valid only with (x,y)=(12,34): req0_grant=1 in the same cycle; next cycle start=1, query=(12,34), outstanding=1. Then ready with r/g/b=(3,7,9): next cycle rsp0_valid=1, rsp=(3,7,9), outstanding=0.
- Both requesters valid continuously, ready never asserted: grants alternate 0,1,0,1,0, then stop; outstanding saturates at 5 and start stays 0 thereafter.
- Full budget (5 in flight), then ready and both valid in the same cycle: one grant is issued that cycle and outstanding stays 5.
- Issue order 1,0,0,1, then 4 ready pulses with distinct colours: rsp valids fire in order 1,0,0,1 and each carries the matching colour.
- ready pulse with outstanding=0: no rsp valid; err=1 and stays 1; a subsequent normal transaction still completes correctly.
- rst_n low for one cycle with 3 in flight: all outputs 0, outstanding=0. A later stray ready pulse sets err.
